seg7_scan: RTL and testbench

Parametrised, time-multiplexed driver for a common-anode, multi-digit 7-segment display. It captures an N-digit hex value plus an overflow flag into a shadow register and scans the digits one at a time at a programmable refresh rate, with a dead-time slot between digits to prevent ghosting. It supports optional leading-zero blanking. It sits between the CPU result/flag bus and the board display pins, and is the multi-digit successor to the single-digit hex decoder.

---
 rtl/seg7_scan.sv | 127 ++++++++++++
 tb/tb_seg7_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Scans a captured hex value digit by digit with a dead-time slot between digits.
module seg7_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    overflow,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_OVF = 7'b0110110;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    ovf_q, ovf_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              digit_s;
    logic                    blanked_s;

    // Next-state logic for prescaler, digit index, shadow and output registers.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        ovf_d     = ovf_q;
        seg_d     = SEG_OFF;
        anode_d   = '1;
        digit_s   = shadow_q[{idx_q, 2'b00} +: 4];
        // A digit is a leading zero when it and everything above it are zero.
        blanked_s = blank_lz && (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);

        if (load) begin
            shadow_d = value;
            ovf_d    = overflow;
        end else begin
            shadow_d = shadow_q;
            ovf_d    = ovf_q;
        end

        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end

        if (cnt_q == '0) begin
            anode_d = '1;
            seg_d   = SEG_OFF;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_d[i] = (idx_q == IW'(i)) ? 1'b0 : 1'b1;
            end
            if (ovf_q) begin
                seg_d = SEG_OVF;
            end else if (blanked_s) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = hex_glyph(digit_s);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
            seg_q    <= SEG_OFF;
            anode_q  <= '1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            seg_q    <= seg_d;
            anode_q  <= anode_d;
        end
    end

    assign seg   = seg_q;
    assign anode = anode_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan using a slot/phase reference model.
module tb_seg7_scan;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        overflow;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  anode;

    int tests = 0;
    int fails = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned e;
    logic [15:0] m_shadow;
    logic        m_ovf;

    seg7_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .overflow (overflow),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .anode    (anode)
    );

    always #5 clk = ~clk;

    task automatic expect_now(input logic [6:0] es, input logic [3:0] ea, input string tag);
        tests++;
        assert (seg === es) else begin
            fails++;
            $error("FAIL %s seg got %b want %b (edge %0d)", tag, seg, es, e);
        end
        tests++;
        assert (anode === ea) else begin
            fails++;
            $error("FAIL %s anode got %b want %b (edge %0d)", tag, anode, ea, e);
        end
    endtask

    task automatic model_reset();
        e        = 0;
        m_shadow = 16'h0000;
        m_ovf    = 1'b0;
    endtask

    task automatic cycle(input string tag);
        int         phase;
        int         dig;
        logic [6:0] es;
        logic [3:0] ea;
        logic [15:0] upper;
        phase = int'(e % R);
        dig   = int'((e / R) % N);
        upper = m_shadow >> (4 * dig);
        if (phase == 0) begin
            es = 7'b1111111;
            ea = 4'b1111;
        end else begin
            ea = ~(4'b0001 << dig);
            if (m_ovf)
                es = 7'b0110110;
            else if (blank_lz && dig > 0 && upper == 16'h0000)
                es = 7'b1111111;
            else
                es = glyph[upper[3:0]];
        end
        @(posedge clk);
        if (load) begin
            m_shadow = value;
            m_ovf    = overflow;
        end
        e++;
        #1;
        expect_now(es, ea, tag);
        tests++;
        assert ($countones(~anode) <= 1) else begin
            fails++;
            $error("FAIL %s onehot got %b want at most one low bit", tag, anode);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic ov, input string tag);
        value    = v;
        overflow = ov;
        load     = 1'b1;
        cycle(tag);
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; value = 16'h0000; overflow = 1'b0; load = 1'b0; blank_lz = 1'b0;
        model_reset();
        #12;
        expect_now(7'b1111111, 4'b1111, "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Post-reset anode sequence 1111,1110,1110,1110,1111,1101
        for (int i = 0; i < 6; i++) cycle("post_reset");

        do_load(16'h3A7F, 1'b0, "scan_load");
        for (int i = 0; i < 32; i++) cycle("scan_3A7F");

        // Asynchronous reset mid-scan, shadow lost
        #2;
        rst = 1'b1;
        #1;
        expect_now(7'b1111111, 4'b1111, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) cycle("after_rst_zero");

        blank_lz = 1'b1;
        do_load(16'h0050, 1'b0, "blank_load");
        for (int i = 0; i < 16; i++) cycle("blank_0050");
        do_load(16'h0000, 1'b0, "blank_zero_load");
        for (int i = 0; i < 16; i++) cycle("blank_0000");

        do_load(16'h0000, 1'b1, "ovf_load");
        for (int i = 0; i < 16; i++) cycle("ovf_glyph");
        blank_lz = 1'b0;
        do_load(16'h1234, 1'b0, "ovf_clear");
        for (int i = 0; i < 16; i++) cycle("ovf_restored");

        value = 16'hFFFF;
        for (int i = 0; i < 16; i++) cycle("shadow_hold");

        // Align to the middle of a digit-0 slot, then load
        for (int i = 0; i < 2 * N * R && !((e % R) == 2 && ((e / R) % N) == 0); i++)
            cycle("align");
        do_load(16'h123C, 1'b0, "midslot_load");
        for (int i = 0; i < 4; i++) cycle("midslot_after");

        for (int i = 0; i < 1000; i++) begin
            value    = 16'($urandom);
            overflow = ($urandom_range(0, 7) == 0);
            load     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
            cycle("random");
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
